// File: rtl/mips_decode_queue.sv
// Instruction queue between fetch and ID with a registered pre-decode stage.
// Produces register-use metadata for hazard detection and holds issue at EHB until the pipe drains.
module mips_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int PC_W  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            pipe_empty,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_dest,
  output logic            out_rs_used,
  output logic            out_rt_used,
  output logic            out_is_load,
  output logic            out_rsvd,
  output logic            ehb_stall
);
  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable while valid && !ready.
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [31:0] EHB     = 32'h0000_00C0;

  localparam logic [5:0] OP_OTHER0 = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_COP0   = 6'h10, OP_DADDI  = 6'h18, OP_DADDIU = 6'h19, OP_SPECIAL3 = 6'h1F;
  localparam logic [5:0] OP_LB     = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25, OP_LWU    = 6'h27, OP_SB   = 6'h28, OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B, OP_BC     = 6'h32, OP_LD   = 6'h37, OP_SD   = 6'h3F;

  typedef struct packed {
    logic [4:0] dest;
    logic       rs_used;
    logic       rt_used;
    logic       is_load;
    logic       rsvd;
  } dec_t;

  logic [PC_W-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [PC_W-1:0] out_pc_q;
  logic [31:0]     out_inst_q;
  dec_t            out_dec_q, dec_d;

  logic [31:0]     head_inst;
  logic [PC_W-1:0] head_pc;
  logic            head_valid, head_is_ehb, out_free, load_out, ehb_pop, pop, push;

  assign head_inst   = inst_mem_q[rd_ptr_q];
  assign head_pc     = pc_mem_q[rd_ptr_q];
  assign head_valid  = (count_q != '0);
  assign head_is_ehb = head_valid && (head_inst == EHB);
  assign out_free    = !out_valid_q || out_ready;
  assign load_out    = head_valid && !head_is_ehb && out_free;
  // The EHB is retired only once nothing older remains in flight.
  assign ehb_pop     = head_is_ehb && pipe_empty && out_free;
  assign pop         = load_out || ehb_pop;
  assign in_ready    = (count_q < DEPTH_C);
  assign push        = in_valid && in_ready && !flush;

  always_comb begin
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    logic       known, is64;
    op = head_inst[31:26];
    rs = head_inst[25:21];
    rt = head_inst[20:16];
    rd = head_inst[15:11];
    sa = head_inst[10:6];
    fn = head_inst[5:0];
    known = 1'b1;
    is64  = 1'b0;
    dec_d = '{dest: 5'd0, rs_used: 1'b1, rt_used: 1'b0, is_load: 1'b0, rsvd: 1'b0};
    case (op)
      OP_OTHER0: begin
        case (fn)
          6'h00, 6'h02, 6'h03: begin dec_d.dest = rd; dec_d.rs_used = 1'b0; dec_d.rt_used = 1'b1; end
          6'h38, 6'h3A, 6'h3B, 6'h3C, 6'h3E: begin
            dec_d.dest = rd; dec_d.rs_used = 1'b0; dec_d.rt_used = 1'b1; is64 = 1'b1;
          end
          6'h04, 6'h05, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin dec_d.dest = rd; dec_d.rt_used = 1'b1; end
          6'h15, 6'h2C, 6'h2D, 6'h2E: begin dec_d.dest = rd; dec_d.rt_used = 1'b1; is64 = 1'b1; end
          6'h08, 6'h0C: ;
          6'h09: dec_d.dest = rd;
          default: known = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          5'h00, 5'h01: ;
          5'h11: dec_d.dest = 5'd31;
          default: known = 1'b0;
        endcase
      end
      OP_J:                   dec_d.rs_used = 1'b0;
      OP_JAL:                 begin dec_d.rs_used = 1'b0; dec_d.dest = 5'd31; end
      OP_BEQ, OP_BNE:         dec_d.rt_used = 1'b1;
      OP_BLEZ, OP_BGTZ:       ;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: dec_d.dest = rt;
      OP_LUI:                 begin dec_d.dest = rt; dec_d.rs_used = 1'b0; end
      OP_DADDI, OP_DADDIU:    begin dec_d.dest = rt; is64 = 1'b1; end
      OP_COP0: begin
        if (rs == 5'h00) begin
          dec_d.dest = rt; dec_d.rs_used = 1'b0; dec_d.is_load = 1'b1;
        end else if (rs == 5'h04) begin
          dec_d.rs_used = 1'b0; dec_d.rt_used = 1'b1;
        end else if (head_inst[25] && fn == 6'h18) begin
          dec_d.rs_used = 1'b0;
        end else begin
          known = 1'b0;
        end
      end
      OP_SPECIAL3: begin
        if (fn == 6'h20 && (sa == 5'h10 || sa == 5'h18)) begin
          dec_d.dest = rd; dec_d.rt_used = 1'b1;
        end else begin
          known = 1'b0;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin dec_d.dest = rt; dec_d.is_load = 1'b1; end
      OP_LWU, OP_LD:          begin dec_d.dest = rt; dec_d.is_load = 1'b1; is64 = 1'b1; end
      OP_SB, OP_SH, OP_SW:    dec_d.rt_used = 1'b1;
      OP_SD:                  begin dec_d.rt_used = 1'b1; is64 = 1'b1; end
      OP_BC:                  dec_d.rs_used = 1'b0;
      default:                known = 1'b0;
    endcase
    dec_d.rsvd = !known || (is64 && XLEN == 32);
    // Reserved entries still issue but must not create false hazards.
    if (dec_d.rsvd) begin
      dec_d.dest = 5'd0; dec_d.rs_used = 1'b0; dec_d.rt_used = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
    out_valid_d = out_valid_q;
    if (load_out)       out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0; rd_ptr_d = '0; count_d = '0; out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_dec_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      if (load_out && !flush) begin
        out_pc_q   <= head_pc;
        out_inst_q <= head_inst;
        out_dec_q  <= dec_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_inst    = out_inst_q;
  assign out_rs      = out_inst_q[25:21];
  assign out_rt      = out_inst_q[20:16];
  assign out_dest    = out_dec_q.dest;
  assign out_rs_used = out_dec_q.rs_used;
  assign out_rt_used = out_dec_q.rt_used;
  assign out_is_load = out_dec_q.is_load;
  assign out_rsvd    = out_dec_q.rsvd;
  assign ehb_stall   = head_is_ehb;
endmodule

// File: tb/tb_mips_decode_queue.sv
// Bench for mips_decode_queue: XLEN=64 and XLEN=32 instances share one stimulus stream
// and are compared every cycle against a queue-level reference model.
module tb_mips_decode_queue;
  localparam int          DEPTH = 4;
  localparam int          PC_W  = 64;
  localparam logic [31:0] EHB   = 32'h0000_00C0;

  logic            clock = 1'b0;
  logic            reset, flush, in_valid, pipe_empty, out_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_inst;

  logic            rdy_64, ov_64, rsu_64, rtu_64, ld_64, rsvd_64, ehb_64;
  logic [PC_W-1:0] pc_64;
  logic [31:0]     inst_64;
  logic [4:0]      rs_64, rt_64, dest_64;
  logic            rdy_32, ov_32, rsu_32, rtu_32, ld_32, rsvd_32, ehb_32;
  logic [PC_W-1:0] pc_32;
  logic [31:0]     inst_32;
  logic [4:0]      rs_32, rt_32, dest_32;

  mips_decode_queue #(.DEPTH(DEPTH), .XLEN(64), .PC_W(PC_W)) dut64 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_64),
    .in_pc(in_pc), .in_inst(in_inst), .pipe_empty(pipe_empty), .out_valid(ov_64),
    .out_ready(out_ready), .out_pc(pc_64), .out_inst(inst_64), .out_rs(rs_64), .out_rt(rt_64),
    .out_dest(dest_64), .out_rs_used(rsu_64), .out_rt_used(rtu_64), .out_is_load(ld_64),
    .out_rsvd(rsvd_64), .ehb_stall(ehb_64));

  mips_decode_queue #(.DEPTH(DEPTH), .XLEN(32), .PC_W(PC_W)) dut32 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_32),
    .in_pc(in_pc), .in_inst(in_inst), .pipe_empty(pipe_empty), .out_valid(ov_32),
    .out_ready(out_ready), .out_pc(pc_32), .out_inst(inst_32), .out_rs(rs_32), .out_rt(rt_32),
    .out_dest(dest_32), .out_rs_used(rsu_32), .out_rt_used(rtu_32), .out_is_load(ld_32),
    .out_rsvd(rsvd_32), .ehb_stall(ehb_32));

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [PC_W+31:0] exp_q[$];
  logic             m_ov = 1'b0;
  logic [PC_W+31:0] m_out = '0;

  logic [31:0] inst_tab [24] = '{
    32'h0085_1021, 32'h0000_00C0, 32'h0000_0000, 32'h0C00_0000, 32'hDC83_0000, 32'h03E0_0008,
    32'h0320_F809, 32'h2442_0001, 32'h3C01_ABCD, 32'h8C43_0004, 32'hAC43_0004, 32'h1085_0003,
    32'h4002_6000, 32'h4082_6000, 32'h4200_0018, 32'h7C05_1420, 32'h0085_102C, 32'h0002_1438,
    32'h0411_0004, 32'hC800_0010, 32'h9C83_0000, 32'hFC83_0000, 32'h0000_000C, 32'h6442_0001};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {dest, rs_used, rt_used, is_load, rsvd} from the instruction-class rules.
  function automatic logic [8:0] ref_decode(input logic [31:0] w, input int xlen);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa, dst;
    logic       known, is64, rsu, rtu, ld, rsvd;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sa = w[10:6]; fn = w[5:0];
    known = 1'b1; is64 = 1'b0; rsu = 1'b1; rtu = 1'b0; ld = 1'b0; dst = 5'd0;
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03}) begin dst = rd; rsu = 0; rtu = 1; end
      else if (fn inside {6'h38, 6'h3A, 6'h3B, 6'h3C, 6'h3E}) begin dst = rd; rsu = 0; rtu = 1; is64 = 1; end
      else if (fn inside {[6'h04:6'h07], [6'h20:6'h27], 6'h2A, 6'h2B}) begin dst = rd; rtu = 1; end
      else if (fn inside {6'h15, 6'h2C, 6'h2D, 6'h2E}) begin dst = rd; rtu = 1; is64 = 1; end
      else if (fn == 6'h09) dst = rd;
      else if (!(fn inside {6'h08, 6'h0C})) known = 0;
    end else if (op == 6'h01) begin
      if (rt == 5'h11) dst = 5'd31;
      else if (!(rt inside {5'h00, 5'h01})) known = 0;
    end
    else if (op == 6'h02) rsu = 0;
    else if (op == 6'h03) begin rsu = 0; dst = 5'd31; end
    else if (op inside {6'h04, 6'h05}) rtu = 1;
    else if (op inside {6'h06, 6'h07}) known = 1;
    else if (op inside {[6'h08:6'h0E]}) dst = rt;
    else if (op == 6'h0F) begin dst = rt; rsu = 0; end
    else if (op inside {6'h18, 6'h19}) begin dst = rt; is64 = 1; end
    else if (op == 6'h10) begin
      if (rs == 5'h00) begin dst = rt; rsu = 0; ld = 1; end
      else if (rs == 5'h04) begin rsu = 0; rtu = 1; end
      else if (w[25] && fn == 6'h18) rsu = 0;
      else known = 0;
    end else if (op == 6'h1F) begin
      if (fn == 6'h20 && sa inside {5'h10, 5'h18}) begin dst = rd; rtu = 1; end
      else known = 0;
    end
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin dst = rt; ld = 1; end
    else if (op inside {6'h27, 6'h37}) begin dst = rt; ld = 1; is64 = 1; end
    else if (op inside {6'h28, 6'h29, 6'h2B}) rtu = 1;
    else if (op == 6'h3F) begin rtu = 1; is64 = 1; end
    else if (op == 6'h32) rsu = 0;
    else known = 0;
    rsvd = !known || (is64 && xlen == 32);
    if (rsvd) begin dst = 5'd0; rsu = 0; rtu = 0; end
    return {dst, rsu, rtu, ld, rsvd};
  endfunction

  function automatic logic [114:0] exp_entry(input logic [PC_W+31:0] e, input int xlen);
    return {e[PC_W+31:32], e[31:0], e[25:21], e[20:16], ref_decode(e[31:0], xlen)};
  endfunction

  // One cycle of the reference model: head moves to the output slot before the new entry lands.
  task automatic model_update(input logic iv, input logic [PC_W-1:0] pc, input logic [31:0] inst,
                              input logic pe, input logic ordy, input logic fl, input logic rst);
    logic acc;
    if (rst || fl) begin
      exp_q.delete();
      m_ov = 1'b0;
      return;
    end
    acc = iv && (exp_q.size() < DEPTH);
    if (!m_ov || ordy) begin
      m_ov = 1'b0;
      if (exp_q.size() > 0) begin
        if (exp_q[0][31:0] == EHB) begin
          if (pe) void'(exp_q.pop_front());
        end else begin
          m_out = exp_q.pop_front();
          m_ov  = 1'b1;
        end
      end
    end
    if (acc) exp_q.push_back({pc, inst});
  endtask

  task automatic compare_all();
    logic ehb_exp;
    ehb_exp = 1'b0;
    if (exp_q.size() > 0) ehb_exp = (exp_q[0][31:0] == EHB);
    check("in_ready64", rdy_64, exp_q.size() < DEPTH);
    check("in_ready32", rdy_32, exp_q.size() < DEPTH);
    check("out_valid64", ov_64, m_ov);
    check("out_valid32", ov_32, m_ov);
    check("ehb_stall64", ehb_64, ehb_exp);
    check("ehb_stall32", ehb_32, ehb_exp);
    if (m_ov) begin
      check("entry64", {pc_64, inst_64, rs_64, rt_64, dest_64, rsu_64, rtu_64, ld_64, rsvd_64},
            exp_entry(m_out, 64));
      check("entry32", {pc_32, inst_32, rs_32, rt_32, dest_32, rsu_32, rtu_32, ld_32, rsvd_32},
            exp_entry(m_out, 32));
    end
  endtask

  // driver: apply inputs at the falling edge, compare after the next falling edge
  task automatic step(input logic iv, input logic [PC_W-1:0] pc, input logic [31:0] inst,
                      input logic pe, input logic ordy, input logic fl, input logic rst,
                      output logic acc);
    in_valid = iv; in_pc = pc; in_inst = inst; pipe_empty = pe;
    out_ready = ordy; flush = fl; reset = rst;
    acc = iv && rdy_64 && !fl && !rst;
    model_update(iv, pc, inst, pe, ordy, fl, rst);
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle(input int n, input logic pe, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, pe, ordy, 1'b0, 1'b0, a);
  endtask

  function automatic logic [31:0] rand_inst();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return inst_tab[$urandom_range(0, 23)];
  endfunction

  initial begin
    logic a;
    int   n;
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, a);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, a);
    check("rst_in_ready", rdy_64, 1);
    check("rst_out_valid", {ov_64, ov_32}, 0);
    check("rst_fields", {pc_64, inst_64, rs_64, rt_64, dest_64, rsu_64, rtu_64, ld_64, rsvd_64, ehb_64}, 0);

    // addu $2,$4,$5
    step(1'b1, 64'h100, 32'h0085_1021, 1'b1, 1'b1, 1'b0, 1'b0, a);
    check("t1_no_bypass", ov_64, 0);
    idle(1, 1'b1, 1'b1);
    check("t1_valid", ov_64, 1);
    check("t1_fields", {dest_64, rs_64, rt_64, rsu_64, rtu_64}, {5'd2, 5'd4, 5'd5, 1'b1, 1'b1});
    idle(2, 1'b1, 1'b1);

    // fill: four queued plus the output register
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'h200 + 64'(i * 4), 32'h2442_0001, 1'b1, 1'b0, 1'b0, 1'b0, a);
      n += int'(a);
    end
    check("t2_accepts", n, 5);
    check("t2_full", rdy_64, 0);
    n = 0;
    step(1'b1, 64'h300, 32'h2442_0001, 1'b1, 1'b1, 1'b0, 1'b0, a);
    n += int'(a);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 64'h304 + 64'(i * 4), 32'h2442_0001, 1'b1, 1'b0, 1'b0, 1'b0, a);
      n += int'(a);
    end
    check("t2_one_more", n, 1);
    idle(8, 1'b1, 1'b1);

    // EHB barrier followed by jal
    step(1'b1, 64'h400, EHB, 1'b0, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 64'h404, 32'h0C00_0000, 1'b0, 1'b1, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0, 1'b1);
      check("t3_stall", {ehb_64, ov_64}, 2'b10);
    end
    idle(1, 1'b1, 1'b1);
    check("t3_stall_drop", ehb_64, 0);
    idle(1, 1'b1, 1'b1);
    check("t3_jal", {ov_64, pc_64, inst_64, dest_64, rsu_64}, {1'b1, 64'h404, 32'h0C00_0000, 5'd31, 1'b0});
    idle(2, 1'b1, 1'b1);

    // ld $3,0($4) under both widths
    step(1'b1, 64'h500, 32'hDC83_0000, 1'b1, 1'b1, 1'b0, 1'b0, a);
    idle(1, 1'b1, 1'b0);
    check("t4_ld32", {ov_32, rsvd_32, dest_32, ld_32}, {1'b1, 1'b1, 5'd0, 1'b1});
    check("t4_ld64", {ov_64, rsvd_64, dest_64, ld_64}, {1'b1, 1'b0, 5'd3, 1'b1});
    idle(2, 1'b1, 1'b1);

    // flush with three queued entries
    for (int i = 0; i < 4; i++) step(1'b1, 64'h600 + 64'(i * 4), 32'h8C43_0004, 1'b1, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 64'h700, 32'h0085_1021, 1'b1, 1'b0, 1'b1, 1'b0, a);
    check("t5_flush", {ov_64, rdy_64, ov_32}, 3'b010);
    for (int i = 0; i < 6; i++) begin
      idle(1, 1'b1, 1'b1);
      check("t5_no_stale", ov_64, 0);
    end

    // reset while full, then while an EHB is stalled
    for (int i = 0; i < 6; i++) step(1'b1, 64'h800 + 64'(i * 4), 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 64'h900, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, a);
    check("rst_full", {rdy_64, ov_64, ehb_64, pc_64}, {1'b1, 1'b0, 1'b0, 64'h0});
    step(1'b1, 64'hA00, EHB, 1'b0, 1'b1, 1'b0, 1'b0, a);
    idle(2, 1'b0, 1'b1);
    check("ehb_before_rst", ehb_64, 1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, a);
    check("rst_ehb", {ehb_64, ehb_32, ov_64}, 0);

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, rand_inst(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0, 1'b0, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
